id_ex_pipe: RTL and testbench

- Parametrised ID→EX pipeline boundary.
- Replaces the fixed-width, always-advancing register with a ready/valid handshake, optional 2-entry skid buffer, flush, and NOP bubble insertion when empty.
- Sits between the decoder and the execute unit.
- Also keeps a saturating back-pressure counter for performance monitoring.

---
 rtl/id_ex_pipe_pkg.sv | 18 +
 rtl/pipe_skid_buf.sv | 131 +++++++++++++
 rtl/id_ex_pipe.sv | 100 ++++++++++
 tb/tb_id_ex_pipe.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pipe_pkg.sv
// Shared constants and types for the ID->EX pipeline boundary.
package id_ex_pipe_pkg;

  localparam logic [7:0]  EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [2:0]  EXE_RES_NOP  = 3'b000;
  localparam logic [4:0]  NOPRegAddr   = 5'b00000;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic        WriteDisable = 1'b0;
  localparam logic        RstEnable    = 1'b1;
  localparam logic        RstEnable_n  = 1'b0;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic ready/valid pipeline register: two-entry skid buffer (SKID=1)
// or a single entry with combinational ready (SKID=0), both with flush.
module pipe_skid_buf
  import id_ex_pipe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data
);

  generate
    if (SKID != 0) begin : g_skid
      skid_state_e       r_state;
      skid_state_e       w_state_next;
      logic              r_in_rdy;
      logic [DATA_W-1:0] r_m_data;
      logic [DATA_W-1:0] r_s_data;
      logic              w_in_xfer;
      logic              w_out_xfer;
      logic              w_load_m;
      logic              w_load_s;
      logic              w_shift;

      // Ready comes from a register so ex_ready never reaches id_ready.
      assign o_ready    = r_in_rdy & ~i_flush;
      assign o_valid    = (r_state != SKID_EMPTY);
      assign o_data     = r_m_data;
      assign w_in_xfer  = i_valid & o_ready;
      assign w_out_xfer = o_valid & i_ready;

      always_comb begin
        w_state_next = r_state;
        w_load_m     = 1'b0;
        w_load_s     = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
          SKID_EMPTY: begin
            if (w_in_xfer) begin
              w_state_next = SKID_ONE;
              w_load_m     = 1'b1;
            end
          end
          SKID_ONE: begin
            if (w_in_xfer && w_out_xfer) begin
              w_load_m = 1'b1;
            end else if (w_in_xfer) begin
              w_state_next = SKID_TWO;
              w_load_s     = 1'b1;
            end else if (w_out_xfer) begin
              w_state_next = SKID_EMPTY;
            end
          end
          SKID_TWO: begin
            if (w_out_xfer) begin
              w_state_next = SKID_ONE;
              w_shift      = 1'b1;
            end
          end
          default: w_state_next = SKID_EMPTY;
        endcase
        if (i_flush) begin
          w_state_next = SKID_EMPTY;
          w_load_m     = 1'b0;
          w_load_s     = 1'b0;
          w_shift      = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable_n) begin
          r_state  <= SKID_EMPTY;
          r_in_rdy <= 1'b0;
          r_m_data <= '0;
          r_s_data <= '0;
        end else begin
          r_state  <= w_state_next;
          r_in_rdy <= (w_state_next != SKID_TWO);
          if (w_load_m) begin
            r_m_data <= i_data;
          end else if (w_shift) begin
            r_m_data <= r_s_data;
          end
          if (w_load_s) begin
            r_s_data <= i_data;
          end
        end
      end
    end else begin : g_single
      logic              r_m_valid;
      logic              r_rst_done;
      logic [DATA_W-1:0] r_m_data;
      logic              w_in_xfer;
      logic              w_out_xfer;

      // r_rst_done keeps ready low until the first edge after reset release.
      assign o_ready    = r_rst_done & (~r_m_valid | i_ready) & ~i_flush;
      assign o_valid    = r_m_valid;
      assign o_data     = r_m_data;
      assign w_in_xfer  = i_valid & o_ready;
      assign w_out_xfer = r_m_valid & i_ready;

      always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable_n) begin
          r_m_valid  <= 1'b0;
          r_rst_done <= 1'b0;
          r_m_data   <= '0;
        end else begin
          r_rst_done <= 1'b1;
          if (i_flush) begin
            r_m_valid <= 1'b0;
          end else if (w_in_xfer) begin
            r_m_valid <= 1'b1;
            r_m_data  <= i_data;
          end else if (w_out_xfer) begin
            r_m_valid <= 1'b0;
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/id_ex_pipe.sv
// ID->EX pipeline boundary: ready/valid register with NOP bubble forcing
// and a saturating back-pressure counter.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ALUOP_W   = 8,
  parameter int ALUSEL_W  = 3,
  parameter int REGADDR_W = 5,
  parameter int SKID      = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 id_valid,
  output logic                 id_ready,
  input  logic [ALUOP_W-1:0]   id_aluop,
  input  logic [ALUSEL_W-1:0]  id_alusel,
  input  logic [XLEN-1:0]      id_s_op1,
  input  logic [XLEN-1:0]      id_s_op2,
  input  logic [REGADDR_W-1:0] id_reg_waddr,
  input  logic                 id_reg_we,
  input  logic [XLEN-1:0]      id_link_addr,
  input  logic [XLEN-1:0]      id_mem_offset,
  input  logic [XLEN-1:0]      id_pc,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [ALUOP_W-1:0]   ex_aluop,
  output logic [ALUSEL_W-1:0]  ex_alusel,
  output logic [XLEN-1:0]      ex_s_op1,
  output logic [XLEN-1:0]      ex_s_op2,
  output logic [REGADDR_W-1:0] ex_reg_waddr,
  output logic                 ex_reg_we,
  output logic [XLEN-1:0]      ex_link_addr,
  output logic [XLEN-1:0]      ex_mem_offset,
  output logic [XLEN-1:0]      ex_pc,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int PAY_W = ALUOP_W + ALUSEL_W + REGADDR_W + 1 + 5 * XLEN;

  logic [PAY_W-1:0]     w_in_pay;
  logic [PAY_W-1:0]     w_out_pay;
  logic                 w_out_valid;
  logic [ALUOP_W-1:0]   w_aluop;
  logic [ALUSEL_W-1:0]  w_alusel;
  logic [XLEN-1:0]      w_s_op1;
  logic [XLEN-1:0]      w_s_op2;
  logic [REGADDR_W-1:0] w_reg_waddr;
  logic                 w_reg_we;
  logic [XLEN-1:0]      w_link_addr;
  logic [XLEN-1:0]      w_mem_offset;
  logic [XLEN-1:0]      w_pc;
  logic [CNT_W-1:0]     r_stall_cnt;

  assign w_in_pay = {id_aluop, id_alusel, id_reg_waddr, id_reg_we, id_s_op1,
                     id_s_op2, id_link_addr, id_mem_offset, id_pc};

  pipe_skid_buf #(
    .DATA_W (PAY_W),
    .SKID   (SKID)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .i_valid (id_valid),
    .o_ready (id_ready),
    .i_data  (w_in_pay),
    .o_valid (w_out_valid),
    .i_ready (ex_ready),
    .o_data  (w_out_pay)
  );

  assign {w_aluop, w_alusel, w_reg_waddr, w_reg_we, w_s_op1,
          w_s_op2, w_link_addr, w_mem_offset, w_pc} = w_out_pay;

  // Stale stored contents never leak: an invalid slot always reads as a NOP.
  assign ex_valid      = w_out_valid;
  assign ex_aluop      = w_out_valid ? w_aluop      : ALUOP_W'(EXE_NOP_OP);
  assign ex_alusel     = w_out_valid ? w_alusel     : ALUSEL_W'(EXE_RES_NOP);
  assign ex_reg_waddr  = w_out_valid ? w_reg_waddr  : REGADDR_W'(NOPRegAddr);
  assign ex_reg_we     = w_out_valid ? w_reg_we     : WriteDisable;
  assign ex_s_op1      = w_out_valid ? w_s_op1      : XLEN'(ZeroWord);
  assign ex_s_op2      = w_out_valid ? w_s_op2      : XLEN'(ZeroWord);
  assign ex_link_addr  = w_out_valid ? w_link_addr  : XLEN'(ZeroWord);
  assign ex_mem_offset = w_out_valid ? w_mem_offset : XLEN'(ZeroWord);
  assign ex_pc         = w_out_valid ? w_pc         : XLEN'(ZeroWord);

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable_n) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !ex_ready && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench: instance A is SKID=1 with a 4-bit stall counter,
// instance B is SKID=0 with the default 16-bit counter.
module tb_id_ex_pipe;
  import id_ex_pipe_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [7:0]  id_aluop;
  logic [2:0]  id_alusel;
  logic [31:0] id_s_op1, id_s_op2, id_link_addr, id_mem_offset, id_pc;
  logic [4:0]  id_reg_waddr;
  logic        id_reg_we;

  logic        id_valid_a, id_ready_a, ex_valid_a, ex_ready_a;
  logic [7:0]  ex_aluop_a;
  logic [2:0]  ex_alusel_a;
  logic [31:0] ex_s_op1_a, ex_s_op2_a, ex_link_addr_a, ex_mem_offset_a, ex_pc_a;
  logic [4:0]  ex_reg_waddr_a;
  logic        ex_reg_we_a;
  logic [3:0]  stall_cnt_a;

  logic        id_valid_b, id_ready_b, ex_valid_b, ex_ready_b;
  logic [7:0]  ex_aluop_b;
  logic [2:0]  ex_alusel_b;
  logic [31:0] ex_s_op1_b, ex_s_op2_b, ex_link_addr_b, ex_mem_offset_b, ex_pc_b;
  logic [4:0]  ex_reg_waddr_b;
  logic        ex_reg_we_b;
  logic [15:0] stall_cnt_b;

  int          n_checks;
  int          n_errors;
  logic        m_valid_mdl;
  logic        exp_rdy;
  logic [31:0] next_in_pc;
  logic [31:0] next_out_pc;

  id_ex_pipe #(.SKID(1), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid_a), .id_ready(id_ready_a),
    .id_aluop(id_aluop), .id_alusel(id_alusel),
    .id_s_op1(id_s_op1), .id_s_op2(id_s_op2),
    .id_reg_waddr(id_reg_waddr), .id_reg_we(id_reg_we),
    .id_link_addr(id_link_addr), .id_mem_offset(id_mem_offset), .id_pc(id_pc),
    .ex_valid(ex_valid_a), .ex_ready(ex_ready_a),
    .ex_aluop(ex_aluop_a), .ex_alusel(ex_alusel_a),
    .ex_s_op1(ex_s_op1_a), .ex_s_op2(ex_s_op2_a),
    .ex_reg_waddr(ex_reg_waddr_a), .ex_reg_we(ex_reg_we_a),
    .ex_link_addr(ex_link_addr_a), .ex_mem_offset(ex_mem_offset_a), .ex_pc(ex_pc_a),
    .stall_cnt(stall_cnt_a)
  );

  id_ex_pipe #(.SKID(0), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid_b), .id_ready(id_ready_b),
    .id_aluop(id_aluop), .id_alusel(id_alusel),
    .id_s_op1(id_s_op1), .id_s_op2(id_s_op2),
    .id_reg_waddr(id_reg_waddr), .id_reg_we(id_reg_we),
    .id_link_addr(id_link_addr), .id_mem_offset(id_mem_offset), .id_pc(id_pc),
    .ex_valid(ex_valid_b), .ex_ready(ex_ready_b),
    .ex_aluop(ex_aluop_b), .ex_alusel(ex_alusel_b),
    .ex_s_op1(ex_s_op1_b), .ex_s_op2(ex_s_op2_b),
    .ex_reg_waddr(ex_reg_waddr_b), .ex_reg_we(ex_reg_we_b),
    .ex_link_addr(ex_link_addr_b), .ex_mem_offset(ex_mem_offset_b), .ex_pc(ex_pc_b),
    .stall_cnt(stall_cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] aluop_of(input logic [31:0] pc);
    return pc[9:2] ^ 8'hA5;
  endfunction

  task automatic present(input logic [31:0] pc);
    id_pc         = pc;
    id_aluop      = aluop_of(pc);
    id_alusel     = 3'b101;
    id_s_op1      = pc + 32'h0000_1000;
    id_s_op2      = pc + 32'h0002_0000;
    id_reg_waddr  = pc[6:2];
    id_reg_we     = 1'b1;
    id_link_addr  = pc + 32'd8;
    id_mem_offset = ~pc;
  endtask

  task automatic chk_pay_a(input string tag, input logic [31:0] pc);
    chk({tag, "_pc"},     ex_pc_a, pc);
    chk({tag, "_aluop"},  32'(ex_aluop_a), 32'(aluop_of(pc)));
    chk({tag, "_alusel"}, 32'(ex_alusel_a), 32'd5);
    chk({tag, "_op1"},    ex_s_op1_a, pc + 32'h0000_1000);
    chk({tag, "_op2"},    ex_s_op2_a, pc + 32'h0002_0000);
    chk({tag, "_waddr"},  32'(ex_reg_waddr_a), 32'(pc[6:2]));
    chk({tag, "_we"},     32'(ex_reg_we_a), 32'd1);
    chk({tag, "_link"},   ex_link_addr_a, pc + 32'd8);
    chk({tag, "_moff"},   ex_mem_offset_a, ~pc);
  endtask

  task automatic chk_pay_b(input string tag, input logic [31:0] pc);
    chk({tag, "_pc"},     ex_pc_b, pc);
    chk({tag, "_aluop"},  32'(ex_aluop_b), 32'(aluop_of(pc)));
    chk({tag, "_alusel"}, 32'(ex_alusel_b), 32'd5);
    chk({tag, "_op1"},    ex_s_op1_b, pc + 32'h0000_1000);
    chk({tag, "_op2"},    ex_s_op2_b, pc + 32'h0002_0000);
    chk({tag, "_waddr"},  32'(ex_reg_waddr_b), 32'(pc[6:2]));
    chk({tag, "_we"},     32'(ex_reg_we_b), 32'd1);
    chk({tag, "_link"},   ex_link_addr_b, pc + 32'd8);
    chk({tag, "_moff"},   ex_mem_offset_b, ~pc);
  endtask

  task automatic chk_nop_a(input string tag);
    chk({tag, "_valid"},  32'(ex_valid_a), 32'd0);
    chk({tag, "_aluop"},  32'(ex_aluop_a), 32'(EXE_NOP_OP));
    chk({tag, "_alusel"}, 32'(ex_alusel_a), 32'(EXE_RES_NOP));
    chk({tag, "_we"},     32'(ex_reg_we_a), 32'(WriteDisable));
    chk({tag, "_waddr"},  32'(ex_reg_waddr_a), 32'(NOPRegAddr));
    chk({tag, "_pc"},     ex_pc_a, ZeroWord);
    chk({tag, "_op1"},    ex_s_op1_a, ZeroWord);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b0;
    flush      = 1'b0;
    id_valid_a = 1'b0;
    ex_ready_a = 1'b0;
    id_valid_b = 1'b0;
    ex_ready_b = 1'b0;
    present(32'h0);

    // Reset state
    repeat (2) @(negedge clk);
    chk_nop_a("rst_a");
    chk("rst_stall_a", 32'(stall_cnt_a), 32'd0);
    chk("rst_id_ready_a", 32'(id_ready_a), 32'd0);
    chk("rst_id_ready_b", 32'(id_ready_b), 32'd0);
    chk("rst_ex_valid_b", 32'(ex_valid_b), 32'd0);
    rst = 1'b1;
    #1 chk("rel_id_ready_a_pre", 32'(id_ready_a), 32'd0);
    @(negedge clk);
    chk("rel_id_ready_a", 32'(id_ready_a), 32'd1);
    chk("rel_id_ready_b", 32'(id_ready_b), 32'd1);

    // Streaming on A
    ex_ready_a = 1'b1;
    id_valid_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      present(32'h100 + 32'(4 * i));
      #1 chk("stream_id_ready", 32'(id_ready_a), 32'd1);
      @(negedge clk);
      chk("stream_valid", 32'(ex_valid_a), 32'd1);
      chk_pay_a("stream", 32'h100 + 32'(4 * i));
      chk("stream_stall", 32'(stall_cnt_a), 32'd0);
      $display("stream xfer pc=0x%0h", ex_pc_a);
    end
    id_valid_a = 1'b0;
    @(negedge clk);
    chk_nop_a("stream_drain");

    // Reset asserted mid-operation
    ex_ready_a = 1'b0;
    id_valid_a = 1'b1;
    present(32'h200);
    @(negedge clk);
    id_valid_a = 1'b0;
    @(negedge clk);
    chk("pre_rst_stall", 32'(stall_cnt_a), 32'd1);
    chk("pre_rst_valid", 32'(ex_valid_a), 32'd1);
    rst = 1'b0;
    #1;
    chk_nop_a("mid_rst");
    chk("mid_rst_stall", 32'(stall_cnt_a), 32'd0);
    chk("mid_rst_id_ready", 32'(id_ready_a), 32'd0);
    repeat (3) @(negedge clk);
    chk("mid_rst_hold_valid", 32'(ex_valid_a), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rel_id_ready", 32'(id_ready_a), 32'd1);
    chk("mid_rel_valid", 32'(ex_valid_a), 32'd0);

    // Back-pressure with A, B, C offered
    ex_ready_a = 1'b0;
    id_valid_a = 1'b1;
    present(32'h300);
    #1 chk("bp_rdy_A", 32'(id_ready_a), 32'd1);
    @(negedge clk);
    chk("bp_valid_A", 32'(ex_valid_a), 32'd1);
    chk("bp_pc_A", ex_pc_a, 32'h300);
    present(32'h304);
    #1 chk("bp_rdy_B", 32'(id_ready_a), 32'd1);
    @(negedge clk);
    present(32'h308);
    #1 chk("bp_rdy_C", 32'(id_ready_a), 32'd0);
    chk("bp_pc_held1", ex_pc_a, 32'h300);
    chk("bp_stall1", 32'(stall_cnt_a), 32'd1);
    @(negedge clk);
    chk("bp_rdy_C2", 32'(id_ready_a), 32'd0);
    chk("bp_pc_held2", ex_pc_a, 32'h300);
    chk("bp_stall2", 32'(stall_cnt_a), 32'd2);
    ex_ready_a = 1'b1;
    #1 chk("bp_rdy_no_comb", 32'(id_ready_a), 32'd0);
    @(negedge clk);
    chk("bp_emit_B", ex_pc_a, 32'h304);
    chk("bp_stall_hold", 32'(stall_cnt_a), 32'd2);
    chk("bp_rdy_after", 32'(id_ready_a), 32'd1);
    @(negedge clk);
    chk_pay_a("bp_emit_C", 32'h308);
    id_valid_a = 1'b0;
    @(negedge clk);
    chk("bp_drained", 32'(ex_valid_a), 32'd0);
    chk("bp_stall_final", 32'(stall_cnt_a), 32'd2);

    // Flush with two entries held and an instruction offered
    ex_ready_a = 1'b0;
    id_valid_a = 1'b1;
    present(32'h400);
    @(negedge clk);
    present(32'h404);
    @(negedge clk);
    chk("fl_pc_held", ex_pc_a, 32'h400);
    chk("fl_rdy_full", 32'(id_ready_a), 32'd0);
    chk("fl_stall_pre", 32'(stall_cnt_a), 32'd3);
    present(32'h408);
    flush = 1'b1;
    #1 chk("fl_rdy_during", 32'(id_ready_a), 32'd0);
    @(negedge clk);
    flush      = 1'b0;
    id_valid_a = 1'b0;
    #1;
    chk_nop_a("fl_after");
    chk("fl_stall_kept", 32'(stall_cnt_a), 32'd4);
    chk("fl_rdy_after", 32'(id_ready_a), 32'd1);
    ex_ready_a = 1'b1;
    @(negedge clk);
    chk("fl_not_accepted", 32'(ex_valid_a), 32'd0);
    chk("fl_stall_final", 32'(stall_cnt_a), 32'd4);

    // SKID=0 with ex_ready toggling 1,0,1,0...
    m_valid_mdl = 1'b0;
    next_in_pc  = 32'h500;
    next_out_pc = 32'h500;
    id_valid_b  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ex_ready_b = ((i % 2) == 0);
      present(next_in_pc);
      #1;
      exp_rdy = ~m_valid_mdl | ex_ready_b;
      chk("b_id_ready", 32'(id_ready_b), 32'(exp_rdy));
      chk("b_ex_valid", 32'(ex_valid_b), 32'(m_valid_mdl));
      if (m_valid_mdl && ex_ready_b) begin
        chk("b_out_pc", ex_pc_b, next_out_pc);
        $display("skid0 xfer pc=0x%0h", ex_pc_b);
        next_out_pc = next_out_pc + 32'd4;
      end
      if (exp_rdy) begin
        m_valid_mdl = 1'b1;
        next_in_pc  = next_in_pc + 32'd4;
      end else if (m_valid_mdl && ex_ready_b) begin
        m_valid_mdl = 1'b0;
      end
      @(negedge clk);
    end
    id_valid_b = 1'b0;
    ex_ready_b = 1'b1;
    #1;
    chk("b_last_valid", 32'(ex_valid_b), 32'd1);
    chk_pay_b("b_last", 32'h50C);
    @(negedge clk);
    chk("b_drained", 32'(ex_valid_b), 32'd0);
    chk("b_stall", 32'(stall_cnt_b), 32'd4);

    // Saturation of the 4-bit counter on A
    ex_ready_a = 1'b0;
    id_valid_a = 1'b1;
    present(32'h600);
    @(negedge clk);
    id_valid_a = 1'b0;
    repeat (10) @(negedge clk);
    chk("sat_14", 32'(stall_cnt_a), 32'd14);
    @(negedge clk);
    chk("sat_15", 32'(stall_cnt_a), 32'd15);
    repeat (9) @(negedge clk);
    chk("sat_hold", 32'(stall_cnt_a), 32'd15);
    chk("sat_valid", 32'(ex_valid_a), 32'd1);
    chk("sat_pc", ex_pc_a, 32'h600);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
